// File: rtl/apb_slave_regfile.sv
`timescale 1ns/1ps
// APB3 completer register bank: reg 0 is a read-only ID, the rest are R/W; misaligned, out-of-range and ID writes error.
// Completes WAIT_STATES+1 cycles into the access phase; PREADY (from registered state only) is the sole backpressure.
module apb_slave_regfile #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_REGS    = 16,
   parameter int                    WAIT_STATES = 1,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA5B0_0001
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic                  PWRITE,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);
   localparam int             IDX_W     = $clog2(NUM_REGS);
   localparam int             CNT_W     = 4;
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_write;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [CNT_W-1:0]      r_wait_cnt;
   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   logic                  w_setup;
   logic                  w_commit;
   logic                  w_dec;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_hi_err;
   logic                  w_err;

   // Any address bit above the register window is an error, so NUM_REGS*4 never aliases index 0.
   assign w_idx    = PADDR[2 +: IDX_W];
   assign w_hi_err = |(PADDR >> (2 + IDX_W));
   assign w_err    = (|PADDR[1:0]) | w_hi_err | (PWRITE & (w_idx == '0));

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_setup     = 1'b0;
      w_commit    = 1'b0;
      w_dec       = 1'b0;
      case (r_state)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               w_state_nxt = ACCESS;
               w_setup     = 1'b1;
            end
         end
         ACCESS: begin
            if (!PSEL) begin
               w_state_nxt = IDLE;
            end else if (PENABLE) begin
               if (r_wait_cnt == '0) begin
                  w_commit    = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_dec = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_idx      <= '0;
         r_write    <= 1'b0;
         r_err      <= 1'b0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_wait_cnt <= '0;
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_regs[0]  <= ID_VALUE;
      end else begin
         if (w_setup) begin
            r_idx      <= w_idx;
            r_write    <= PWRITE;
            r_err      <= w_err;
            r_wdata    <= PWDATA;
            r_wait_cnt <= WAIT_INIT;
            r_rdata    <= (!PWRITE && !w_err) ? r_regs[w_idx] : '0;
         end
         if (w_dec) r_wait_cnt <= r_wait_cnt - 1'b1;
         // Index 0 writes always carry r_err, so the ID entry is never overwritten.
         if (w_commit && r_write && !r_err) r_regs[r_idx] <= r_wdata;
      end
   end

   assign PREADY  = (r_state == ACCESS) && (r_wait_cnt == '0);
   assign PSLVERR = PREADY & r_err;
   assign PRDATA  = (PREADY && !r_write) ? r_rdata : '0;

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB3 completer: a bank of memory-mapped 32-bit registers with a configurable number of wait states and error signalling.
- It is the responder on the APB side of the AHB-to-APB bridge, which drives PSEL/PENABLE/PADDR/PWRITE/PWDATA and consumes PRDATA.
- It is the target for bridge integration tests and the template for future APB peripherals.

Parameters:
- ADDR_WIDTH, 32, width of PADDR.
- DATA_WIDTH, 32, width of PWDATA/PRDATA and of each register.
- NUM_REGS, 16, number of registers; power of two, >= 2.
- WAIT_STATES, 1, PREADY-low cycles inserted in each access phase (0..15).
- ID_VALUE, 32'hA5B0_0001, read-only contents of register 0.

Ports:
- PCLK  input  1  clock.
- PRESETn  input  1  asynchronous active-low reset.
- PSEL  input  1  completer select.
- PENABLE  input  1  access-phase indicator.
- PADDR  input  ADDR_WIDTH  byte address.
- PWRITE  input  1  1 = write, 0 = read.
- PWDATA  input  DATA_WIDTH  write data.
- PRDATA  output  DATA_WIDTH  read data; valid when PREADY=1 and the transfer is a read.
- PREADY  output  1  transfer completes this cycle.
- PSLVERR  output  1  error response; valid only while PREADY=1.

Behaviour:
- Interface: one clock, PCLK; reset PRESETn is asynchronous and active-low.
- Reset values: state=IDLE, all registers 0 except register 0 (fixed at ID_VALUE), PRDATA=0, PREADY=0, PSLVERR=0, wait counter=0.
- All outputs are decoded from registered state only; there is no combinational path from inputs to outputs.

FSM states: IDLE, ACCESS.
- IDLE -> ACCESS when PSEL=1 and PENABLE=0 (setup phase).
  - On that edge, capture addr_q, write_q, wdata_q and err_q.
  - Load wait_cnt=WAIT_STATES.
  - If the access is a valid read, load rdata_q from the addressed register; otherwise load rdata_q=0.
- ACCESS with PENABLE=1 and wait_cnt!=0: decrement wait_cnt; PREADY=0.
- ACCESS with wait_cnt==0: PREADY=1 and PSLVERR=err_q.
  - Commit: if write_q=1 and err_q=0, reg[index]<=wdata_q at this edge.
  - Next state IDLE.
- ACCESS with PSEL=0 (protocol violation, aborted transfer): go to IDLE; no register update; PREADY stays 0.
- PENABLE=0 while in ACCESS with PSEL=1 (violation): hold wait_cnt; no completion.

Timing and outputs:
- Latency: completion occurs in access-phase cycle WAIT_STATES+1. With WAIT_STATES=0 the access completes in its first cycle (two-cycle APB transfer).
- PRDATA = rdata_q while PREADY=1 and write_q=0; 0 otherwise.
- Back-to-back transfers: the completion cycle returns to IDLE. The next setup phase is accepted in the following cycle, so there are no dead cycles beyond the APB setup phase.

Decode:
- index = PADDR[2 +: log2(NUM_REGS)].
- err_q=1 if any of:
  - PADDR[1:0]!=0;
  - any PADDR bit at or above position 2+log2(NUM_REGS) is set;
  - the access is a write to index 0 (read-only ID).
- An error read returns PRDATA=0. An error write changes no state.

Boundary conditions:
- Last register (index NUM_REGS-1) is valid.
- Address NUM_REGS*4 is an error; it must not wrap to index 0.
- PRESETn asserted mid-access: immediately IDLE, outputs return to reset values, the pending write is dropped, registers are cleared.

Test Plan:
1. Write 0xDEADBEEF to 0x04 with WAIT_STATES=1, then read 0x04. Required: each access sees PREADY=0 for 1 cycle then 1, PSLVERR=0, and the read returns PRDATA=0xDEADBEEF.
2. Read 0x00 -> PRDATA=0xA5B00001, PSLVERR=0. Write 0x12345678 to 0x00 -> PSLVERR=1 on the completion cycle; a re-read still returns 0xA5B00001.
3. Read 0x40 (NUM_REGS=16) and write 0x06 -> PSLVERR=1 for both. The read returns PRDATA=0. Registers 0 and 1 are unchanged.
4. WAIT_STATES=0: back-to-back writes of 0x11 to 0x08 and 0x22 to 0x0C, setup phases adjacent to completions. Required: PREADY=1 in the first access cycle of each, and reads return 0x11 and 0x22.
5. Write 0xCAFEF00D to 0x3C and drop PSEL during a wait cycle. Required: PREADY never asserts, FSM returns to IDLE, and 0x3C still reads 0.
6. Write 0x55 to 0x10, then assert PRESETn=0 during the wait state of a write of 0xAA to 0x10. Required: PREADY=0 and PSLVERR=0 immediately, and after release 0x10 reads 0.
